// File: rtl/wa_pkg.sv
// -----------------------------------------------------------------------------
// wa_pkg
// Shared types, widths, default parameter values and saturating helpers for
// the workload analyzer (workload_analyzer) and its run-length predictor
// datapath (wa_run_predictor).
// -----------------------------------------------------------------------------
package wa_pkg;

    // Width of run length, prediction and confidence values.
    localparam int WA_W = 8;

    // Default tuning values.
    localparam int DEF_ALPHA_SHIFT  = 2;
    localparam int DEF_ERR_TOL      = 2;
    localparam int DEF_CONF_INC     = 16;
    localparam int DEF_CONF_DEC     = 32;
    localparam int DEF_WINDOW_RUNS  = 4;
    localparam int DEF_DELTA_TH     = 2;
    localparam int DEF_COOLDOWN_CYC = 16;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        EVAL     = 2'd1,
        REQ      = 2'd2,
        COOLDOWN = 2'd3
    } wa_state_t;

    // a + b, clamped at the all-ones value.
    function automatic logic [WA_W-1:0] sat_add8(input logic [WA_W-1:0] a,
                                                 input logic [WA_W-1:0] b);
        logic [WA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[WA_W] ? {WA_W{1'b1}} : sum[WA_W-1:0];
    endfunction

    // a - b, clamped at zero.
    function automatic logic [WA_W-1:0] sat_sub8(input logic [WA_W-1:0] a,
                                                 input logic [WA_W-1:0] b);
        return (a >= b) ? (a - b) : {WA_W{1'b0}};
    endfunction

endpackage

// File: rtl/wa_run_predictor.sv
// -----------------------------------------------------------------------------
// wa_run_predictor
// Purely combinational datapath evaluated on every run-end: computes the next
// EWMA run-length prediction and the next prediction-accuracy confidence.
//
// Ports:
//   run_len   in  8  length L of the run that just ended
//   pred      in  8  current predicted run length
//   conf      in  8  current confidence
//   pred_new  out 8  (pred*(2^S-1) + L + 2^(S-1)) >> S
//   conf_new  out 8  conf +CONF_INC if |L-pred| <= ERR_TOL, else -CONF_DEC
//                    (both saturating)
// -----------------------------------------------------------------------------
module wa_run_predictor
    import wa_pkg::*;
#(
    parameter int ALPHA_SHIFT = DEF_ALPHA_SHIFT,
    parameter int ERR_TOL     = DEF_ERR_TOL,
    parameter int CONF_INC    = DEF_CONF_INC,
    parameter int CONF_DEC    = DEF_CONF_DEC
) (
    input  logic [WA_W-1:0] run_len,
    input  logic [WA_W-1:0] pred,
    input  logic [WA_W-1:0] conf,
    output logic [WA_W-1:0] pred_new,
    output logic [WA_W-1:0] conf_new
);

    localparam int              ROUND_I    = (ALPHA_SHIFT > 0) ? (1 << (ALPHA_SHIFT - 1)) : 0;
    localparam logic [15:0]     ROUND      = 16'(ROUND_I);
    localparam logic [WA_W-1:0] ERR_TOL_W  = WA_W'(ERR_TOL);
    localparam logic [WA_W-1:0] CONF_INC_W = WA_W'(CONF_INC);
    localparam logic [WA_W-1:0] CONF_DEC_W = WA_W'(CONF_DEC);

    logic [15:0]     acc;
    logic [15:0]     acc_shr;
    logic [WA_W-1:0] err;

    always_comb begin
        // pred*(2^S-1) is formed as (pred << S) - pred; with an 8-bit pred the
        // 16-bit sum cannot overflow and the shifted result fits in 8 bits.
        acc      = ({8'd0, pred} << ALPHA_SHIFT) - {8'd0, pred} + {8'd0, run_len} + ROUND;
        acc_shr  = acc >> ALPHA_SHIFT;
        pred_new = acc_shr[WA_W-1:0];

        err = (run_len >= pred) ? (run_len - pred) : (pred - run_len);

        if (err <= ERR_TOL_W) begin
            conf_new = sat_add8(conf, CONF_INC_W);
        end else begin
            conf_new = sat_sub8(conf, CONF_DEC_W);
        end
    end

endmodule

// File: rtl/workload_analyzer.sv
// -----------------------------------------------------------------------------
// workload_analyzer
// Watches the issued instruction stream, measures runs of consecutive
// arithmetic instructions, keeps a smoothed run-length prediction plus a
// confidence figure, and pulses wa_req to the mode arbiter when a window of
// run-ends completes and the prediction has moved far enough since the last
// request.
//
// Ports:
//   clk               in   1  clock
//   rst_n             in   1  synchronous active-low reset
//   instr_valid       in   1  one instruction issued this cycle
//   instr_is_arith    in   1  issued instruction is arithmetic
//   pipe_flush        in   1  discards the current partial run
//   wa_req            out  1  single-cycle evaluation request
//   confidence        out  8  prediction confidence 0..255
//   predicted_runlen  out  8  smoothed arithmetic run length
//   run_end_cnt       out 16  (WA_STATS_EN only) run-end events, wrapping
//   req_cnt           out 16  (WA_STATS_EN only) requests issued, wrapping
//
// Build option: define WA_STATS_EN to add the two statistics counters.
// -----------------------------------------------------------------------------
module workload_analyzer
    import wa_pkg::*;
#(
    parameter int ALPHA_SHIFT  = DEF_ALPHA_SHIFT,
    parameter int ERR_TOL      = DEF_ERR_TOL,
    parameter int CONF_INC     = DEF_CONF_INC,
    parameter int CONF_DEC     = DEF_CONF_DEC,
    parameter int WINDOW_RUNS  = DEF_WINDOW_RUNS,
    parameter int DELTA_TH     = DEF_DELTA_TH,
    parameter int COOLDOWN_CYC = DEF_COOLDOWN_CYC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic            instr_is_arith,
    input  logic            pipe_flush,
    output logic            wa_req,
    output logic [WA_W-1:0] confidence,
    output logic [WA_W-1:0] predicted_runlen
`ifdef WA_STATS_EN
    ,
    output logic [15:0]     run_end_cnt,
    output logic [15:0]     req_cnt
`endif
);

    localparam int WIN_W = (WINDOW_RUNS > 1) ? $clog2(WINDOW_RUNS) : 1;
    localparam int CD_W  = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;

    localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WINDOW_RUNS - 1);
    localparam logic [CD_W-1:0]  CD_LOAD    = CD_W'(COOLDOWN_CYC - 1);
    localparam logic [WA_W-1:0]  DELTA_TH_W = WA_W'(DELTA_TH);

    wa_state_t        state, next_state;
    logic [WA_W-1:0]  cur_run;
    logic [WA_W-1:0]  pred;
    logic [WA_W-1:0]  conf;
    logic [WA_W-1:0]  snapshot;
    logic             first_req;
    logic [WIN_W-1:0] win_cnt, win_cnt_nxt;
    logic [CD_W-1:0]  cd_cnt, cd_cnt_nxt;

    logic             run_end;
    logic [WA_W-1:0]  pred_new;
    logic [WA_W-1:0]  conf_new;
    logic [WA_W-1:0]  pred_delta;

    // A flush outranks any instruction in the same cycle, so it suppresses
    // the run-end that a non-arithmetic instruction would otherwise cause.
    assign run_end = instr_valid && !instr_is_arith && (cur_run != '0) && !pipe_flush;

    assign pred_delta = (pred >= snapshot) ? (pred - snapshot) : (snapshot - pred);

    wa_run_predictor #(
        .ALPHA_SHIFT (ALPHA_SHIFT),
        .ERR_TOL     (ERR_TOL),
        .CONF_INC    (CONF_INC),
        .CONF_DEC    (CONF_DEC)
    ) u_pred (
        .run_len  (cur_run),
        .pred     (pred),
        .conf     (conf),
        .pred_new (pred_new),
        .conf_new (conf_new)
    );

    // ---------------------------------------------------------------------
    // Next-state logic. EVAL looks at the registered (already updated)
    // prediction, so it sees the stats produced by the window-closing run.
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        next_state  = state;
        win_cnt_nxt = win_cnt;
        cd_cnt_nxt  = cd_cnt;

        unique case (state)
            COLLECT: begin
                if (run_end) begin
                    if (win_cnt == WIN_LAST) begin
                        next_state  = EVAL;
                        win_cnt_nxt = '0;
                    end else begin
                        win_cnt_nxt = win_cnt + 1'b1;
                    end
                end
            end
            EVAL: begin
                if (first_req || (pred_delta >= DELTA_TH_W)) begin
                    next_state = REQ;
                end else begin
                    next_state = COLLECT;
                end
            end
            REQ: begin
                next_state = COOLDOWN;
                cd_cnt_nxt = CD_LOAD;
            end
            COOLDOWN: begin
                if (cd_cnt == '0) begin
                    next_state = COLLECT;
                end else begin
                    cd_cnt_nxt = cd_cnt - 1'b1;
                end
            end
            default: next_state = COLLECT;
        endcase
    end

    // ---------------------------------------------------------------------
    // State and datapath registers.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state     <= COLLECT;
            win_cnt   <= '0;
            cd_cnt    <= '0;
            cur_run   <= '0;
            pred      <= '0;
            conf      <= '0;
            snapshot  <= '0;
            first_req <= 1'b1;
            wa_req    <= 1'b0;
        end else begin
            state   <= next_state;
            win_cnt <= win_cnt_nxt;
            cd_cnt  <= cd_cnt_nxt;

            // Registered decode: high exactly during the REQ cycle.
            wa_req <= (next_state == REQ);

            // Bubbles (instr_valid=0) neither extend nor break a run.
            if (pipe_flush) begin
                cur_run <= '0;
            end else if (instr_valid && instr_is_arith) begin
                cur_run <= sat_add8(cur_run, 8'd1);
            end else if (instr_valid) begin
                cur_run <= '0;
            end

            // Stats follow every run-end, whatever the FSM is doing.
            if (run_end) begin
                pred <= pred_new;
                conf <= conf_new;
            end

            if (state == REQ) begin
                snapshot  <= pred;
                first_req <= 1'b0;
            end
        end
    end

    assign predicted_runlen = pred;
    assign confidence       = conf;

`ifdef WA_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_end_cnt <= '0;
            req_cnt     <= '0;
        end else begin
            if (run_end) begin
                run_end_cnt <= run_end_cnt + 16'd1;
            end
            if (state == REQ) begin
                req_cnt <= req_cnt + 16'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_workload_analyzer.sv
// -----------------------------------------------------------------------------
// tb_workload_analyzer
// Directed stimulus with hand-computed expectations. Stimulus pushes the
// expected prediction/confidence for the cycle after each instruction of
// interest, and the expected wa_req cycle, into queues; a monitor on the
// falling edge pops and compares. wa_req is compared every cycle.
// -----------------------------------------------------------------------------
module tb_workload_analyzer;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_is_arith;
    logic       pipe_flush;
    logic       wa_req;
    logic [7:0] confidence;
    logic [7:0] predicted_runlen;
`ifdef WA_STATS_EN
    logic [15:0] run_end_cnt;
    logic [15:0] req_cnt;
`endif

    workload_analyzer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .instr_valid      (instr_valid),
        .instr_is_arith   (instr_is_arith),
        .pipe_flush       (pipe_flush),
        .wa_req           (wa_req),
        .confidence       (confidence),
        .predicted_runlen (predicted_runlen)
`ifdef WA_STATS_EN
        ,
        .run_end_cnt      (run_end_cnt),
        .req_cnt          (req_cnt)
`endif
    );

    typedef struct {
        int         cyc;
        logic [7:0] pred;
        logic [7:0] conf;
        string      tag;
    } stat_exp_t;

    stat_exp_t stat_q[$];
    int        req_q[$];

    int n_cmp  = 0;
    int n_bad  = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: during the cycle after edge k, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------------
    // Monitor
    // ---------------------------------------------------------------------
    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_req;
            while (req_q.size() > 0 && req_q[0] < cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL req_stale: expected pulse at cyc %0d not consumed (now %0d)", req_q[0], cyc);
                void'(req_q.pop_front());
            end
            exp_req = (req_q.size() > 0) && (req_q[0] == cyc);
            n_cmp++;
            if (wa_req !== exp_req) begin
                n_bad++;
                $display("FAIL wa_req cyc=%0d got=%b want=%b", cyc, wa_req, exp_req);
            end
            if (exp_req) void'(req_q.pop_front());

            while (stat_q.size() > 0 && stat_q[0].cyc < cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL stat_stale %s: expectation for cyc %0d not consumed", stat_q[0].tag, stat_q[0].cyc);
                void'(stat_q.pop_front());
            end
            if (stat_q.size() > 0 && stat_q[0].cyc == cyc) begin
                stat_exp_t e;
                e = stat_q.pop_front();
                n_cmp++;
                if (predicted_runlen !== e.pred) begin
                    n_bad++;
                    $display("FAIL pred %s cyc=%0d got=%0d want=%0d", e.tag, cyc, predicted_runlen, e.pred);
                end
                n_cmp++;
                if (confidence !== e.conf) begin
                    n_bad++;
                    $display("FAIL conf %s cyc=%0d got=%0d want=%0d", e.tag, cyc, confidence, e.conf);
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic drive(input logic v, input logic a, input logic f);
        instr_valid    = v;
        instr_is_arith = a;
        pipe_flush     = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_stats(input logic [7:0] p, input logic [7:0] c, input string tag);
        stat_exp_t e;
        e.cyc  = cyc;
        e.pred = p;
        e.conf = c;
        e.tag  = tag;
        stat_q.push_back(e);
    endtask

    // n arithmetic instructions then one non-arithmetic; the run-end is
    // sampled at the last edge, so stats are checked in the following cycle
    // and a request (if any) is expected one cycle after that.
    task automatic run(input int n, input logic [7:0] p, input logic [7:0] c,
                       input bit req, input string tag);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        expect_stats(p, c, tag);
        if (req) req_q.push_back(cyc + 1);
    endtask

    // ---------------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------------
    initial begin
        rst_n          = 1'b0;
        instr_valid    = 1'b0;
        instr_is_arith = 1'b0;
        pipe_flush     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        expect_stats(8'd0, 8'd0, "reset");
        idle(1);

        // Four runs of 8: pred 2,4,5,6, conf stays 0, first request.
        run(8, 8'd2, 8'd0, 1'b0, "w1r1");
        run(8, 8'd4, 8'd0, 1'b0, "w1r2");
        run(8, 8'd5, 8'd0, 1'b0, "w1r3");
        run(8, 8'd6, 8'd0, 1'b1, "w1r4");
        idle(20);

        // Fifth run of 8: pred 7, err 2 -> accurate.
        run(8, 8'd7, 8'd16, 1'b0, "r5");

        // Twenty runs of 7 at pred 7: conf climbs by 16 and saturates.
        // Windows close with pred 7 vs snapshot 6 -> no request.
        for (int k = 1; k <= 20; k++) begin
            int c;
            c = (16 + 16 * k > 255) ? 255 : 16 + 16 * k;
            run(7, 8'd7, 8'(c), 1'b0, "len7");
        end

        // Long run: pred (21+20+2)>>2 = 10, err 13 -> 255-32.
        run(20, 8'd10, 8'd223, 1'b0, "len20");
        run(10, 8'd10, 8'd239, 1'b0, "len10a");
        // Window closes with pred 10 vs snapshot 6 -> request.
        run(10, 8'd10, 8'd255, 1'b1, "len10b");
        idle(20);

        // 300 arith saturates L at 255: (30+255+2)>>2 = 71.
        run(300, 8'd71, 8'd223, 1'b0, "sat255");

        // Partial run discarded by a flush that coincides with a non-arith,
        // then a lone non-arith: no run-end, stats unchanged.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        expect_stats(8'd71, 8'd223, "flush");
        drive(1'b1, 1'b0, 1'b0);
        expect_stats(8'd71, 8'd223, "post_flush");

        // Bubbles inside a run (one carrying a stale arith flag): L = 4.
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        expect_stats(8'd54, 8'd191, "bubble");

        run(8, 8'd43, 8'd159, 1'b0, "w_r3");
        // Window closes only if the flush added no run-end: pred 34 vs 10.
        run(8, 8'd34, 8'd127, 1'b1, "w_r4");
        idle(20);

        // Reset mid-window with a partial run in flight.
        run(8, 8'd28, 8'd95, 1'b0, "pre_rst");
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        expect_stats(8'd0, 8'd0, "mid_reset");

        // After reset the first window requests again.
        run(8, 8'd2, 8'd0, 1'b0, "w2r1");
        run(8, 8'd4, 8'd0, 1'b0, "w2r2");
        run(8, 8'd5, 8'd0, 1'b0, "w2r3");
        run(8, 8'd6, 8'd0, 1'b1, "w2r4");
        idle(20);

        idle(3);
        mon_en = 1'b0;
        if (stat_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL stat_left: %0d expectations never checked", stat_q.size());
        end
        if (req_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL req_left: %0d expected pulses never seen", req_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
